// File: rtl/cpu_mbox_pkg.sv
// Shared constants for the CPU path mailbox: register offsets, FSM encoding, INIT length.
package cpu_mbox_pkg;

  localparam logic [31:0] OFS_SP   = 32'h0;
  localparam logic [31:0] OFS_EP   = 32'h4;
  localparam logic [31:0] OFS_NODE = 32'h8;
  localparam logic [31:0] OFS_DONE = 32'hC;

  localparam int unsigned INIT_CYCLES = 8;

  typedef logic [2:0] state_t;
  localparam state_t StIdle   = 3'd0;
  localparam state_t StInit   = 3'd1;
  localparam state_t StRun    = 3'd2;
  localparam state_t StStream = 3'd3;
  localparam state_t StDone   = 3'd4;
  localparam state_t StErr    = 3'd5;

endpackage

// File: rtl/cpu_path_mailbox_if.sv
// Valid/ready stream carrying captured path node ids out of the mailbox.
interface cpu_path_mailbox_if #(
  parameter int unsigned NODE_W = 5
);
  logic [NODE_W-1:0] path_node;
  logic              path_valid;
  logic              path_ready;
  logic              path_last;

  modport master (output path_node, output path_valid, output path_last, input path_ready);
  modport slave  (input path_node, input path_valid, input path_last, output path_ready);
endinterface

// File: rtl/mbox_node_buf.sv
// Path node buffer: DEPTH x NODE_W registers, zero-latency read, synchronous clear.
module mbox_node_buf #(
  parameter int unsigned NODE_W = 5,
  parameter int unsigned DEPTH  = 32,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              push_i,
  input  logic [NODE_W-1:0] push_data_i,
  input  logic              pop_i,
  output logic [NODE_W-1:0] rd_data_o,
  output logic [CW-1:0]     count_o,
  output logic              full_o,
  output logic              last_o
);

  logic [NODE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push;

  assign full_o    = (count_q == CW'(DEPTH));
  assign do_push   = push_i && !full_o;
  assign rd_data_o = mem_q[rd_ptr_q[AW-1:0]];
  assign count_o   = count_q;
  // Reads never run concurrently with writes, so the read index counts reads, not slots.
  assign last_o    = ((rd_ptr_q + CW'(1)) == count_q);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        count_d  = count_q + CW'(1);
      end
      if (pop_i) begin
        rd_ptr_d = rd_ptr_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !clr_i) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

endmodule

// File: rtl/cpu_path_mailbox.sv
// Host-side mailbox: seeds and releases the path-planner core, captures the nodes it
// reports, then replays them on a valid/ready stream with length and error flags.
module cpu_path_mailbox
  import cpu_mbox_pkg::*;
#(
  parameter int unsigned NODE_W      = 5,
  parameter int unsigned DEPTH       = 32,
  parameter logic [31:0] BASE_ADR    = 32'h0200_0000,
  parameter int unsigned TIMEOUT_CYC = 3125000,
  localparam int unsigned LW         = $clog2(DEPTH) + 1
) (
  input  logic                clk_3125KHz,
  input  logic                rst_n,
  input  logic                start,
  input  logic [NODE_W-1:0]   sp,
  input  logic [NODE_W-1:0]   ep,
  input  logic                cpu_memwrite,
  input  logic [31:0]         cpu_dataadr,
  input  logic [31:0]         cpu_writedata,
  output logic                cpu_reset,
  output logic                ext_memwrite,
  output logic [31:0]         ext_dataadr,
  output logic [31:0]         ext_writedata,
  cpu_path_mailbox_if.master  path_if,
  output logic [LW-1:0]       path_len,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic                timeout,
  output logic                ep_mismatch
);

  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_t            state_q, state_d;
  logic [2:0]        init_cnt_q, init_cnt_d;
  logic [TW-1:0]     run_cnt_q, run_cnt_d;
  logic [NODE_W-1:0] sp_q, sp_d, ep_q, ep_d;
  logic              start_q;
  logic              overflow_q, overflow_d, timeout_q, timeout_d, ep_mismatch_q, ep_mismatch_d;

  logic              buf_clr, buf_push, buf_pop, buf_full, buf_last;
  logic [NODE_W-1:0] buf_rd_data;
  logic [LW-1:0]     buf_count;

  logic start_edge, node_wr, done_wr, run_expired;

  assign start_edge  = start && !start_q;
  assign node_wr     = cpu_memwrite && (cpu_dataadr == BASE_ADR + OFS_NODE);
  assign done_wr     = cpu_memwrite && (cpu_dataadr == BASE_ADR + OFS_DONE) &&
                       (cpu_writedata == 32'd1);
  assign run_expired = (TIMEOUT_CYC != 0) && (run_cnt_q == TW'(TIMEOUT_CYC - 1));

  mbox_node_buf #(
    .NODE_W (NODE_W),
    .DEPTH  (DEPTH)
  ) u_node_buf (
    .clk_i       (clk_3125KHz),
    .rst_ni      (rst_n),
    .clr_i       (buf_clr),
    .push_i      (buf_push),
    .push_data_i (cpu_writedata[NODE_W-1:0]),
    .pop_i       (buf_pop),
    .rd_data_o   (buf_rd_data),
    .count_o     (buf_count),
    .full_o      (buf_full),
    .last_o      (buf_last)
  );

  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    run_cnt_d     = run_cnt_q;
    sp_d          = sp_q;
    ep_d          = ep_q;
    overflow_d    = overflow_q;
    timeout_d     = timeout_q;
    ep_mismatch_d = ep_mismatch_q;
    buf_clr       = 1'b0;
    buf_push      = 1'b0;
    buf_pop       = 1'b0;
    case (state_q)
      StIdle: begin
        if (start_edge) begin
          sp_d          = sp;
          ep_d          = ep;
          overflow_d    = 1'b0;
          timeout_d     = 1'b0;
          ep_mismatch_d = 1'b0;
          buf_clr       = 1'b1;
          init_cnt_d    = '0;
          state_d       = StInit;
        end
      end
      StInit: begin
        init_cnt_d = init_cnt_q + 3'd1;
        if (init_cnt_q == 3'(INIT_CYCLES - 1)) begin
          run_cnt_d = '0;
          state_d   = StRun;
        end
      end
      StRun: begin
        run_cnt_d = run_cnt_q + TW'(1);
        if (node_wr) begin
          if (buf_full) overflow_d = 1'b1;
          else          buf_push   = 1'b1;
        end
        // A DONE report on the same cycle as expiry still counts as a completed run.
        if (done_wr) begin
          state_d = (buf_count == '0) ? StDone : StStream;
        end else if (run_expired) begin
          timeout_d = 1'b1;
          state_d   = StErr;
        end
      end
      StStream: begin
        if (path_if.path_ready) begin
          buf_pop = 1'b1;
          if (buf_last) begin
            ep_mismatch_d = (buf_rd_data != ep_q);
            state_d       = StDone;
          end
        end
      end
      StDone, StErr: begin
        if (!start) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    ext_memwrite  = 1'b0;
    ext_dataadr   = '0;
    ext_writedata = '0;
    if (state_q == StInit && !init_cnt_q[0]) begin
      ext_memwrite = 1'b1;
      case (init_cnt_q[2:1])
        2'd0: begin
          ext_dataadr   = BASE_ADR + OFS_SP;
          ext_writedata = 32'(sp_q);
        end
        2'd1: begin
          ext_dataadr   = BASE_ADR + OFS_EP;
          ext_writedata = 32'(ep_q);
        end
        2'd2:    ext_dataadr = BASE_ADR + OFS_NODE;
        default: ext_dataadr = BASE_ADR + OFS_DONE;
      endcase
    end
  end

  assign cpu_reset          = (state_q != StRun);
  assign busy               = (state_q != StIdle) && (state_q != StDone);
  assign done               = (state_q == StDone);
  assign path_if.path_valid = (state_q == StStream);
  assign path_if.path_node  = (state_q == StStream) ? buf_rd_data : '0;
  assign path_if.path_last  = (state_q == StStream) && buf_last;
  assign path_len           = buf_count;
  assign overflow           = overflow_q;
  assign timeout            = timeout_q;
  assign ep_mismatch        = ep_mismatch_q;

  always_ff @(posedge clk_3125KHz or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      init_cnt_q    <= '0;
      run_cnt_q     <= '0;
      sp_q          <= '0;
      ep_q          <= '0;
      start_q       <= 1'b0;
      overflow_q    <= 1'b0;
      timeout_q     <= 1'b0;
      ep_mismatch_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      init_cnt_q    <= init_cnt_d;
      run_cnt_q     <= run_cnt_d;
      sp_q          <= sp_d;
      ep_q          <= ep_d;
      start_q       <= start;
      overflow_q    <= overflow_d;
      timeout_q     <= timeout_d;
      ep_mismatch_q <= ep_mismatch_d;
    end
  end

endmodule
